// File: rtl/dff_pkg.sv
// Shared defaults for the d_flip_flop register cell and its stages.
package dff_pkg;

  localparam int DFF_DEFAULT_WIDTH = 1;
  localparam int DFF_DEFAULT_STAGES = 1;
  // Replicated to WIDTH bits by users to form the all-zeros default reset value.
  localparam logic DFF_ZERO_BIT = 1'b0;

endpackage

// File: rtl/d_flip_flop_if.sv
// Signal bundle for one d_flip_flop instance; qn is present only when DFF_QN_EN is defined.
interface d_flip_flop_if
  import dff_pkg::*;
#(
  parameter int WIDTH = DFF_DEFAULT_WIDTH
) (
  input logic clk
);

  logic             clr;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
`ifdef DFF_QN_EN
  logic [WIDTH-1:0] qn;

  modport master (input clk, output clr, output d, input q, input qn);
  modport slave  (input clk, input clr, input d, output q, output qn);
`else
  modport master (input clk, output clr, output d, input q);
  modport slave  (input clk, input clr, input d, output q);
`endif

endinterface

// File: rtl/dff_stage.sv
// One WIDTH-bit register with synchronous active-low clear to RESET_VALUE.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DFF_ZERO_BIT}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Clear takes priority over data; the data register is cleared too, since
  // downstream logic relies on a known value after clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/d_flip_flop.sv
// Parameterizable D register: STAGES cascaded dff_stage cells, synchronous active-low clear.
// Optional complementary output qn is built when macro DFF_QN_EN is defined.
module d_flip_flop
  import dff_pkg::*;
#(
  parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
  parameter int               STAGES      = DFF_DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DFF_ZERO_BIT}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef DFF_QN_EN
  ,
  output logic [WIDTH-1:0] qn
`endif
);

  // w_stage[0] is the input; w_stage[k+1] is the output of stage k.
  logic [WIDTH-1:0] w_stage [STAGES+1];

  assign w_stage[0] = d;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    dff_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk (clk),
      .clr (clr),
      .d   (w_stage[k]),
      .q   (w_stage[k+1])
    );
  end

  assign q = w_stage[STAGES];

`ifdef DFF_QN_EN
  assign qn = ~w_stage[STAGES];
`endif

endmodule

// File: tb/tb_d_flip_flop.sv
// Randomized self-checking bench for d_flip_flop in three configurations sharing clr and d.
module tb_d_flip_flop;
  import dff_pkg::*;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  d_flip_flop_if #(.WIDTH(1)) if1 (.clk(clk));
  d_flip_flop_if #(.WIDTH(8)) if8 (.clk(clk));
  d_flip_flop_if #(.WIDTH(4)) if4 (.clk(clk));

  assign if1.clr = if8.clr;
  assign if4.clr = if8.clr;
  assign if1.d   = if8.d[0];
  assign if4.d   = if8.d[3:0];

  d_flip_flop u_dut1 (
    .clk (clk), .clr (if1.clr), .d (if1.d), .q (if1.q)
`ifdef DFF_QN_EN
    , .qn (if1.qn)
`endif
  );

  d_flip_flop #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk (clk), .clr (if8.clr), .d (if8.d), .q (if8.q)
`ifdef DFF_QN_EN
    , .qn (if8.qn)
`endif
  );

  d_flip_flop #(.WIDTH(4)) u_dut4 (
    .clk (clk), .clr (if4.clr), .d (if4.d), .q (if4.q)
`ifdef DFF_QN_EN
    , .qn (if4.qn)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic       hist_clr [$];
  logic [7:0] hist_d   [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output after the latest edge: reset value if clear was seen in the last
  // S edges, otherwise the data captured S edges ago.
  function automatic logic [7:0] model(input int s, input logic [7:0] rv);
    int n = hist_clr.size();
    int look = (n < s) ? n : s;
    for (int i = 0; i < look; i++) begin
      if (hist_clr[n-1-i] == 1'b0) return rv;
    end
    if (n < s) return 8'hxx;
    return hist_d[n-s];
  endfunction

  task automatic check_all();
    logic [7:0] e1, e8, e4;
    e1 = model(1, 8'h00) & 8'h01;
    e8 = model(3, 8'hA5);
    e4 = model(1, 8'h00) & 8'h0F;
    chk("q_w1", {31'd0, if1.q}, {24'd0, e1});
    chk("q_w8s3", {24'd0, if8.q}, {24'd0, e8});
    chk("q_w4", {28'd0, if4.q}, {24'd0, e4});
`ifdef DFF_QN_EN
    chk("qn_w4", {28'd0, if4.qn}, {28'd0, ~e4[3:0]});
    chk("qn_w8s3", {24'd0, if8.qn}, {24'd0, ~e8});
`endif
  endtask

  task automatic step(input logic c, input logic [7:0] dv);
    if8.clr = c;
    if8.d   = dv;
    @(posedge clk);
    hist_clr.push_back(c);
    hist_d.push_back(dv);
    #2;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    if8.clr = 1'b0;
    if8.d   = 8'h00;
    @(negedge clk);

    // Clear with d=1 on the same edge
    step(1'b0, 8'hFF);
    chk("clear_q1", {31'd0, if1.q}, 32'd0);
    chk("clear_q8", {24'd0, if8.q}, 32'hA5);

    // Pipeline: A5 for two more edges, then 3C on the third
    step(1'b1, 8'h3C);
    chk("pipe_e1", {24'd0, if8.q}, 32'hA5);
    step(1'b1, 8'h00);
    chk("pipe_e2", {24'd0, if8.q}, 32'hA5);
    step(1'b1, 8'h00);
    chk("pipe_e3", {24'd0, if8.q}, 32'h3C);

    // Capture sequence 0,1,0,1
    step(1'b1, 8'h00); chk("cap0", {31'd0, if1.q}, 32'd0);
    step(1'b1, 8'h01); chk("cap1", {31'd0, if1.q}, 32'd1);
    step(1'b1, 8'h00); chk("cap2", {31'd0, if1.q}, 32'd0);
    step(1'b1, 8'h01); chk("cap3", {31'd0, if1.q}, 32'd1);

    // Clear priority over d=1, then release captures d immediately
    step(1'b0, 8'h01); chk("prio_clr", {31'd0, if1.q}, 32'd0);
    step(1'b1, 8'h01); chk("prio_rel", {31'd0, if1.q}, 32'd1);

    // qn for the 4-bit instance: 1010 captured
    step(1'b1, 8'h0A); chk("cap_w4", {28'd0, if4.q}, 32'hA);

    // Short clr pulse between edges must be ignored
    #1 if8.clr = 1'b0;
    #2 if8.clr = 1'b1;
    #1 check_all();
    chk("glitch_q1", {31'd0, if1.q}, 32'd0);
    chk("glitch_q4", {28'd0, if4.q}, 32'hA);
    @(negedge clk);
    hist_clr.push_back(1'b1);
    hist_d.push_back(8'h0A);
    #2 check_all();

    // Clear after capture drives qn to all ones
    step(1'b0, 8'h0A);
    chk("clr_w4", {28'd0, if4.q}, 32'h0);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 7) != 0), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
